// File: rtl/program_sequencer_stk.sv
// Program sequencer with a hardware call/return stack, pipeline hold and sticky stack-error flag.
// pm_addr is the combinational next fetch address; pc registers it every cycle.
module program_sequencer_stk #(
  parameter int ADDR_W      = 8,
  parameter int JMP_W       = 4,
  parameter int STACK_DEPTH = 4,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  input  logic               hold,
  input  logic               jmp,
  input  logic               jmp_nz,
  input  logic               dont_jmp,
  input  logic               call,
  input  logic               ret,
  input  logic [JMP_W-1:0]   jmp_addr,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  from_PS,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               stack_err
);

  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_err;
  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0]  w_pcInc;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_top;
  logic               w_advance;
  logic               w_push;

  assign w_pcInc   = r_pc + ADDR_W'(1);
  assign w_target  = ADDR_W'(jmp_addr) << (ADDR_W - JMP_W);
  assign w_advance = !sync_reset && !hold;
  assign w_push    = w_advance && !ret && call && (r_depth != FULL);

  // Top of stack; an empty stack makes ret behave as a plain increment.
  always_comb begin
    w_top = w_pcInc;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_depth == DEPTH_W'(i + 1)) w_top = r_stack[i];
    end
  end

  always_comb begin
    if (!reset_n)                          pm_addr = '0;
    else if (sync_reset)                   pm_addr = '0;
    else if (hold)                         pm_addr = r_pc;
    else if (ret)                          pm_addr = w_top;
    else if (call || jmp || (jmp_nz && !dont_jmp)) pm_addr = w_target;
    else                                   pm_addr = w_pcInc;
  end

  // Reset value of all ones makes the first fetch after release land on address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pc <= '1;
    else          r_pc <= pm_addr;
  end

  // ret outranks call, so a simultaneous call neither pushes nor flags an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (sync_reset) begin
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (w_advance) begin
      if (ret) begin
        if (r_depth != '0) r_depth <= r_depth - DEPTH_W'(1);
        else               r_err   <= 1'b1;
      end else if (call) begin
        if (r_depth != FULL) r_depth <= r_depth + DEPTH_W'(1);
        else                 r_err   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (r_depth == DEPTH_W'(i)) r_stack[i] <= w_pcInc;
      end
    end
  end

  assign pc          = r_pc;
  assign from_PS     = r_pc;
  assign stack_depth = r_depth;
  assign stack_err   = r_err;

endmodule

// File: tb/tb_program_sequencer_stk.sv
// Directed bench for program_sequencer_stk with default parameters (ADDR_W=8, JMP_W=4, STACK_DEPTH=4).
// Inputs change #1 after the rising edge; outputs are compared at that same point.
module tb_program_sequencer_stk;

   logic       clk;
   logic       reset_n;
   logic       sync_reset;
   logic       hold;
   logic       jmp;
   logic       jmp_nz;
   logic       dont_jmp;
   logic       call;
   logic       ret;
   logic [3:0] jmp_addr;
   logic [7:0] pm_addr;
   logic [7:0] pc;
   logic [7:0] from_PS;
   logic [2:0] stack_depth;
   logic       stack_err;

   int nCompared;
   int nMismatched;

   program_sequencer_stk dut (
      .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .hold(hold),
      .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .call(call), .ret(ret),
      .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pc(pc), .from_PS(from_PS),
      .stack_depth(stack_depth), .stack_err(stack_err)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearControls();
      sync_reset = 1'b0; hold = 1'b0; jmp = 1'b0; jmp_nz = 1'b0;
      dont_jmp = 1'b0; call = 1'b0; ret = 1'b0; jmp_addr = 4'h0;
   endtask

   task automatic test_reset();
      clearControls();
      reset_n = 1'b0;
      repeat (3) tick();
      nCompared++; if (pm_addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL rst_pm_addr got %h want 00", pm_addr); end
      nCompared++; if (pc !== 8'hFF) begin nMismatched++; $display("[TB] FAIL rst_pc got %h want FF", pc); end
      nCompared++; if (stack_depth !== 3'd0) begin nMismatched++; $display("[TB] FAIL rst_depth got %0d want 0", stack_depth); end
      nCompared++; if (stack_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_err got %b want 0", stack_err); end
      reset_n = 1'b1;
      #1;
      nCompared++; if (pm_addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL rel_pm_addr got %h want 00", pm_addr); end
      for (int i = 0; i < 4; i++) begin
         tick();
         nCompared++; if (pc !== 8'(i)) begin nMismatched++; $display("[TB] FAIL rel_pc%0d got %h want %h", i, pc, 8'(i)); end
         nCompared++; if (from_PS !== 8'(i)) begin nMismatched++; $display("[TB] FAIL rel_from_ps%0d got %h want %h", i, from_PS, 8'(i)); end
      end
      nCompared++; if (stack_depth !== 3'd0 || stack_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL rel_stack got depth=%0d err=%b want 0/0", stack_depth, stack_err); end
   endtask

   task automatic test_wrap_jumps();
      repeat (252) tick();
      nCompared++; if (pc !== 8'hFF) begin nMismatched++; $display("[TB] FAIL run_to_ff got %h want FF", pc); end
      tick();
      nCompared++; if (pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL wrap got %h want 00", pc); end
      jmp = 1'b1; jmp_addr = 4'hA;
      #1;
      nCompared++; if (pm_addr !== 8'hA0) begin nMismatched++; $display("[TB] FAIL jmp_pm_addr got %h want A0", pm_addr); end
      tick();
      clearControls();
      nCompared++; if (pc !== 8'hA0) begin nMismatched++; $display("[TB] FAIL jmp got %h want A0", pc); end
      jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'h3;
      tick();
      nCompared++; if (pc !== 8'hA1) begin nMismatched++; $display("[TB] FAIL jmp_nz_suppressed got %h want A1", pc); end
      dont_jmp = 1'b0;
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h30) begin nMismatched++; $display("[TB] FAIL jmp_nz_taken got %h want 30", pc); end
   endtask

   task automatic test_call_ret();
      jmp = 1'b1; jmp_addr = 4'h1;
      tick();
      clearControls();
      repeat (2) tick();
      nCompared++; if (pc !== 8'h12) begin nMismatched++; $display("[TB] FAIL pre_call got %h want 12", pc); end
      call = 1'b1; jmp_addr = 4'h5;
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h50 || stack_depth !== 3'd1) begin nMismatched++; $display("[TB] FAIL call got pc=%h depth=%0d want 50/1", pc, stack_depth); end
      repeat (2) tick();
      ret = 1'b1;
      #1;
      nCompared++; if (pm_addr !== 8'h13) begin nMismatched++; $display("[TB] FAIL ret_pm_addr got %h want 13", pm_addr); end
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h13 || stack_depth !== 3'd0) begin nMismatched++; $display("[TB] FAIL ret got pc=%h depth=%0d want 13/0", pc, stack_depth); end
      call = 1'b1; jmp_addr = 4'h2;
      tick();
      clearControls();
      tick();
      call = 1'b1; jmp_addr = 4'h4;
      tick();
      jmp_addr = 4'h6;
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h60 || stack_depth !== 3'd3) begin nMismatched++; $display("[TB] FAIL nest got pc=%h depth=%0d want 60/3", pc, stack_depth); end
      ret = 1'b1;
      tick();
      nCompared++; if (pc !== 8'h41 || stack_depth !== 3'd2) begin nMismatched++; $display("[TB] FAIL pop1 got pc=%h depth=%0d want 41/2", pc, stack_depth); end
      tick();
      nCompared++; if (pc !== 8'h22 || stack_depth !== 3'd1) begin nMismatched++; $display("[TB] FAIL pop2 got pc=%h depth=%0d want 22/1", pc, stack_depth); end
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h14 || stack_depth !== 3'd0) begin nMismatched++; $display("[TB] FAIL pop3 got pc=%h depth=%0d want 14/0", pc, stack_depth); end
      nCompared++; if (stack_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL nest_err got %b want 0", stack_err); end
   endtask

   task automatic test_overflow();
      call = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         jmp_addr = 4'(i);
         tick();
      end
      clearControls();
      nCompared++; if (pc !== 8'h50) begin nMismatched++; $display("[TB] FAIL ovf_pc got %h want 50", pc); end
      nCompared++; if (stack_depth !== 3'd4) begin nMismatched++; $display("[TB] FAIL ovf_depth got %0d want 4", stack_depth); end
      nCompared++; if (stack_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_err got %b want 1", stack_err); end
      ret = 1'b1;
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h31 || stack_depth !== 3'd3) begin nMismatched++; $display("[TB] FAIL ovf_top got pc=%h depth=%0d want 31/3", pc, stack_depth); end
      nCompared++; if (stack_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL err_sticky got %b want 1", stack_err); end
      sync_reset = 1'b1;
      #1;
      nCompared++; if (pm_addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL sync_pm_addr got %h want 00", pm_addr); end
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h00 || stack_depth !== 3'd0 || stack_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL sync got pc=%h depth=%0d err=%b want 00/0/0", pc, stack_depth, stack_err); end
      repeat (7) tick();
      nCompared++; if (pc !== 8'h07) begin nMismatched++; $display("[TB] FAIL pre_udf got %h want 07", pc); end
      ret = 1'b1;
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h08 || stack_depth !== 3'd0 || stack_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL udf got pc=%h depth=%0d err=%b want 08/0/1", pc, stack_depth, stack_err); end
   endtask

   task automatic test_hold_priority();
      sync_reset = 1'b1;
      tick();
      clearControls();
      call = 1'b1; jmp_addr = 4'h9;
      tick();
      nCompared++; if (pc !== 8'h90 || stack_depth !== 3'd1 || stack_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL hp_call got pc=%h depth=%0d err=%b want 90/1/0", pc, stack_depth, stack_err); end
      hold = 1'b1; jmp_addr = 4'hC;
      for (int i = 0; i < 2; i++) begin
         #1;
         nCompared++; if (pm_addr !== 8'h90) begin nMismatched++; $display("[TB] FAIL hold_pm_addr%0d got %h want 90", i, pm_addr); end
         tick();
         nCompared++; if (pc !== 8'h90 || stack_depth !== 3'd1) begin nMismatched++; $display("[TB] FAIL hold%0d got pc=%h depth=%0d want 90/1", i, pc, stack_depth); end
      end
      hold = 1'b0; ret = 1'b1;
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h01 || stack_depth !== 3'd0 || stack_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL call_ret got pc=%h depth=%0d err=%b want 01/0/0", pc, stack_depth, stack_err); end
   endtask

   task automatic test_async_reset();
      ret = 1'b1;
      tick();
      clearControls();
      call = 1'b1; jmp_addr = 4'h3;
      tick();
      jmp_addr = 4'h4;
      tick();
      clearControls();
      nCompared++; if (pc !== 8'h40 || stack_depth !== 3'd2 || stack_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL pre_arst got pc=%h depth=%0d err=%b want 40/2/1", pc, stack_depth, stack_err); end
      #2;
      reset_n = 1'b0;
      #1;
      nCompared++; if (pc !== 8'hFF || stack_depth !== 3'd0 || stack_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL arst got pc=%h depth=%0d err=%b want FF/0/0", pc, stack_depth, stack_err); end
      nCompared++; if (pm_addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL arst_pm_addr got %h want 00", pm_addr); end
      tick();
      reset_n = 1'b1;
      tick();
      nCompared++; if (pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL arst_release got %h want 00", pc); end
   endtask

   // Scenarios run back to back; each one starts from the state the previous left.
   initial begin
      nCompared = 0;
      nMismatched = 0;
      reset_n = 1'b0;
      clearControls();
      test_reset();
      test_wrap_jumps();
      test_call_ret();
      test_overflow();
      test_hold_priority();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/program_sequencer_stk.md
Name: program_sequencer_stk

Overview:
Parametrised next-generation program sequencer for the processor core. It generates the combinational program-memory address and the registered program counter. It adds a hardware call/return stack, a pipeline hold, and sticky stack-error reporting, and generalises address and jump-field widths. It sits between the instruction decoder (which drives the jump/call controls) and the program memory.

Parameters:
ADDR_W, 8, width of pm_addr/pc/from_PS; legal range 4..16.
JMP_W, 4, width of jmp_addr; target = {jmp_addr, (ADDR_W-JMP_W) zeros}; 1 <= JMP_W <= ADDR_W.
STACK_DEPTH, 4, number of return-address entries; legal range 1..16.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
sync_reset  input  1  synchronous restart from decoder, active-high.
hold  input  1  stall: refetch current pc, no state change.
jmp  input  1  unconditional jump.
jmp_nz  input  1  conditional jump, taken when dont_jmp=0.
dont_jmp  input  1  zero flag from ALU; suppresses jmp_nz.
call  input  1  push return address, jump to target.
ret  input  1  pop return address, jump to it.
jmp_addr  input  JMP_W  jump/call target high bits.
pm_addr  output  ADDR_W  combinational next fetch address.
pc  output  ADDR_W  registered current address.
from_PS  output  ADDR_W  debug tap, equals pc.
stack_depth  output  $clog2(STACK_DEPTH+1)  current number of valid stack entries.
stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (reset_n low, asynchronous): pc = all ones, stack_depth = 0, stack_err = 0, stack contents don't-care. pm_addr is forced to 0 while reset_n is low. After release, pm_addr = pc+1 = 0, so the first fetch is address 0.
- pc <= pm_addr on every rising edge, including during hold (pm_addr = pc, so pc is unchanged).
- pm_addr priority (highest first):
  1. sync_reset -> 0.
  2. hold -> pc.
  3. ret -> top of stack; if the stack is empty -> pc+1.
  4. call -> target.
  5. jmp -> target.
  6. jmp_nz && !dont_jmp -> target.
  7. Otherwise pc+1, modulo 2^ADDR_W (all ones wraps to 0).
- Stack updates occur on the clock edge, only when sync_reset=0 and hold=0:
  - ret with depth>0: pop (depth-1).
  - ret with depth=0: no pop; stack_err <= 1.
  - call (with ret=0) and depth<STACK_DEPTH: push pc+1 (modulo wrap), depth+1.
  - call when full: jump still taken; push discarded; depth unchanged; stack_err <= 1.
- Simultaneous call and ret: ret wins; the call is ignored entirely, with no push and no error from the call.
- Controls (call, jmp, jmp_nz) that lose priority are ignored for that cycle.
- sync_reset at the clock edge: depth <= 0, stack_err <= 0; pc <= 0 via pm_addr.
- Error flag: stack_err stays set until reset_n or sync_reset.
- from_PS is identical to pc at all times.
- Stack storage is a register array indexed by depth. No memory inference is required; there is no read latency, because the top of stack is visible combinationally.

Test Plan:
- Reset release: hold reset_n=0 for 3 clocks, then release with no controls -> pm_addr=0 during reset; pc sequence 0,1,2,3 on subsequent edges; stack_depth=0; stack_err=0.
- Wrap and jumps (defaults): run to pc=0xFF -> next pc=0x00. jmp with jmp_addr=0xA -> pc=0xA0. jmp_nz with dont_jmp=1 -> pc+1. jmp_nz with dont_jmp=0, jmp_addr=0x3 -> pc=0x30.
- Call/return: at pc=0x12, call with jmp_addr=0x5 -> pc=0x50, depth=1. Run to 0x52, then ret -> pc=0x13, depth=0. Nested calls to depth 3, then 3 rets -> return addresses popped in LIFO order.
- Overflow/underflow: 5 calls with STACK_DEPTH=4 -> 5th still jumps, depth stays 4, stack_err=1. After sync_reset: pc=0, depth=0, err=0. Then ret on empty stack at pc=0x07 -> pc=0x08, stack_err=1.
- Hold and priority: hold with call asserted for 2 cycles -> pc and depth frozen. Release with call+ret both asserted and depth=1 -> pop only, depth=0.
- Async reset mid-operation: assert reset_n=0 between clock edges at depth=2, stack_err=1 -> immediately pc=0xFF, depth=0, err=0, pm_addr=0.
